// File: rtl/reg_if_pkg.sv
// Definitions shared by the FX2 command-side register manager and the
// readback reply path: address width and reply-serialiser state encoding.
package reg_if_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CKSUM = 2'd3
    } tx_state_e;

    // Byte-index counter width: clog2(n) bits, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_reply_tx_if.sv
// Reply-path bundle: readback replies in from device logic, bytes out to the
// FX2 IN FIFO. The slave modport is the serialiser's view.
interface reg_reply_tx_if #(
    parameter int DATA_BYTES = 4
);
    import reg_if_pkg::*;

    logic [ADDR_W-1:0]       reply_addr;
    logic [8*DATA_BYTES-1:0] reply_data;
    logic                    reply_valid;
    logic                    reply_ready;
    logic                    tx_full;
    logic [7:0]              tx_byte;
    logic                    tx_wr;
    logic                    busy;

    modport master (
        output reply_addr, reply_data, reply_valid, tx_full,
        input  reply_ready, tx_byte, tx_wr, busy
    );

    modport slave (
        input  reply_addr, reply_data, reply_valid, tx_full,
        output reply_ready, tx_byte, tx_wr, busy
    );

endinterface

// File: rtl/reg_reply_tx_reply_fifo.sv
// Synchronous reply queue: power-of-2 depth, pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module reply_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and an unreset array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/reg_reply_tx.sv
// Register readback reply serialiser: queues {addr, data} replies and emits
// them as byte frames (addr, data LSB first) into the FX2 IN FIFO.
// Define REG_REPLY_CKSUM_EN to append an XOR checksum byte to every frame.
module reg_reply_tx
    import reg_if_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 4
) (
    input logic          clk,
    input logic          reset,
    reg_reply_tx_if.slave bus
);

    localparam int                FIFO_W   = ADDR_W + 8 * DATA_BYTES;
    localparam int                IDX_W    = idx_width(DATA_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BYTES - 1);

    tx_state_e                   state;
    logic [IDX_W-1:0]            idx;
    logic [ADDR_W-1:0]           frame_addr;
    logic [DATA_BYTES-1:0][7:0]  frame_data;
`ifdef REG_REPLY_CKSUM_EN
    logic [7:0]                  cksum;
`endif

    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic [FIFO_W-1:0] q_rdata;
    logic              tx_wr;
    logic [7:0]        tx_byte;

    // Ready reflects registered queue status only; a pop never frees a slot
    // for a push in the same cycle.
    assign bus.reply_ready = !q_full;
    assign q_push          = bus.reply_valid && !q_full;
    assign q_pop           = (state == ST_IDLE) && !q_empty;

    reply_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_reply_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .wdata ({bus.reply_addr, bus.reply_data}),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    // Reset gates the strobe so a byte is never handed over while the frame
    // is being abandoned.
    assign tx_wr = !reset && (state != ST_IDLE) && !bus.tx_full;

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        tx_byte = '0;
        case (state)
            ST_ADDR:  tx_byte = frame_addr;
            ST_DATA:  tx_byte = frame_data[idx];
`ifdef REG_REPLY_CKSUM_EN
            ST_CKSUM: tx_byte = cksum;
`endif
            default:  tx_byte = '0;
        endcase
    end

    assign bus.tx_wr   = tx_wr;
    assign bus.tx_byte = tx_byte;
    assign bus.busy    = (state != ST_IDLE) || !q_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_addr <= '0;
            frame_data <= '0;
`ifdef REG_REPLY_CKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        {frame_addr, frame_data} <= q_rdata;
                        state                    <= ST_ADDR;
`ifdef REG_REPLY_CKSUM_EN
                        cksum                    <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (tx_wr) begin
                        state <= ST_DATA;
                        idx   <= '0;
`ifdef REG_REPLY_CKSUM_EN
                        cksum <= cksum ^ frame_addr;
`endif
                    end
                end
                ST_DATA: begin
                    if (tx_wr) begin
`ifdef REG_REPLY_CKSUM_EN
                        cksum <= cksum ^ frame_data[idx];
`endif
                        if (idx == LAST_IDX) begin
`ifdef REG_REPLY_CKSUM_EN
                            state <= ST_CKSUM;
`else
                            state <= ST_IDLE;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef REG_REPLY_CKSUM_EN
                ST_CKSUM: begin
                    if (tx_wr)
                        state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_reply_tx.md
Name: reg_reply_tx

Overview:
- Return-path partner of the FX2 command/register-write path.
- Accepts register readback replies (address plus data word) from device logic and queues them in a small FIFO.
- Serialises each reply into a byte frame for the FX2 IN-direction FIFO, honouring the FIFO full flag.
- Sits between the register bank/readback mux and the FX2 interface's reply byte FIFO.

Parameters:
- DATA_BYTES, 4, number of data bytes per reply (1..4); data sent LSB first.
- DEPTH, 4, reply queue depth in entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- reply_addr  in  8  register address being reported.
- reply_data  in  8*DATA_BYTES  register value.
- reply_valid  in  1  reply offered this cycle.
- reply_ready  out  1  reply accepted when valid && ready.
- tx_full  in  1  FX2 reply FIFO full; no write may occur while high.
- tx_byte  out  8  byte presented to FX2 FIFO.
- tx_wr  out  1  write strobe; byte consumed on every cycle tx_wr=1.
- busy  out  1  high when the frame is in progress or the queue is non-empty.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (reset).
- Reset values:
  - state=IDLE, queue empty.
  - reply_ready=1 on the first cycle after reset; tx_wr=0, tx_byte=0, busy=0.
  - Reset asserted mid-frame abandons the partial frame and flushes the queue. tx_wr is 0 during the reset cycle.
- Queue:
  - reply_ready = !queue_full, registered-status, with no same-cycle bypass.
  - A push when full is impossible because ready is low.
  - A push and a pop in the same cycle are both performed.
- Frame register: holds the reply being sent. It loads from the queue head when state=IDLE and the queue is non-empty (pop).
- Capacity: DEPTH+1 replies (DEPTH in the queue, 1 in the frame register).
- FSM:
  - IDLE: if queue non-empty, pop into the frame register, go to ADDR. Otherwise stay.
  - ADDR: tx_byte=addr. On write, go to DATA with idx=0.
  - DATA: tx_byte=data byte idx. On write, idx++. When idx==DATA_BYTES-1 is written, go to CKSUM if enabled, else IDLE.
  - CKSUM (optional): tx_byte=running checksum. On write, go to IDLE.
- Write rule:
  - tx_wr = (state != IDLE) && !tx_full, combinational from registered state and tx_full.
  - The FSM advances only on cycles with tx_wr=1.
  - tx_byte is stable while tx_full holds the frame.
- Latency:
  - A reply accepted in cycle N enters the queue at edge N.
  - It is popped in cycle N+1.
  - Its address byte may be written in cycle N+2.
- Inter-frame gap: exactly one IDLE cycle (tx_wr=0) between back-to-back frames.
- Width: idx counter is clog2(DATA_BYTES) bits, minimum 1. Queue pointers wrap modulo DEPTH, with an extra bit for full/empty discrimination.

Optional Feature:
- REG_REPLY_CKSUM_EN defined: each frame is appended with one byte equal to the XOR of the address and all data bytes.
  - The checksum accumulator clears on pop.
  - Frame length is DATA_BYTES+2.
- Not defined: no CKSUM state; frame length is DATA_BYTES+1.

Decomposition:
- Shared package (reg_if_pkg) holds:
  - FSM state encoding constants (IDLE=0, ADDR=1, DATA=2, CKSUM=3).
  - The address width constant (8), shared with the command-side register manager.
- One natural sub-module: reply_fifo, a synchronous FIFO of width 8+8*DATA_BYTES and depth DEPTH with push, pop, full, empty and synchronous reset.

Test Plan:
- Single reply, tx_full=0: addr=0x12, data=0x89ABCDEF.
  - Expected: tx_wr high on 5 consecutive cycles with bytes 12,EF,CD,AB,89.
  - With REG_REPLY_CKSUM_EN: sixth byte 12. busy falls after the last byte.
- Backpressure: same reply, tx_full high for 3 cycles while byte CD is presented.
  - Expected: tx_wr=0 for those 3 cycles, CD held, then CD,AB,89 follow with no loss or duplication.
- Capacity: DEPTH=4, tx_full held high, reply_valid held high.
  - Expected: exactly 5 replies accepted, then reply_ready=0.
  - After releasing tx_full, all 5 frames emerge in order.
- Back-to-back: two replies (addr 01/data 00000001, addr 02/data 00000002) queued.
  - Expected: frames in order with exactly one cycle of tx_wr=0 between them.
- Reset mid-frame: reset asserted for 1 cycle after 2 bytes of a frame with 2 more replies queued.
  - Expected: tx_wr=0 and no further bytes, busy=0, reply_ready=1.
  - A new reply afterwards produces a complete, correct frame.
- Simultaneous push/pop: queue full and IDLE while reply_valid=1.
  - Expected: the pop occurs, and reply_ready rises the next cycle, not the same cycle.
